// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter slice: default bus widths,
// requester ids and the lock state encoding.
package grom_mem_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 12;
  localparam int unsigned DEF_DATA_WIDTH = 8;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUX = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side and RAM-side signals of the arbiter, grouped as one bundle.
interface ram_arbiter_if
  import grom_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  req0, req1;
  logic                  we0, we1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  lock0, lock1;
  logic                  gnt0, gnt1;
  logic                  rvalid0, rvalid1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_data_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    input  ram_data_out,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output ram_addr, ram_data_in, ram_we
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    output ram_data_out,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  ram_addr, ram_data_in, ram_we
  );

endinterface

// File: rtl/ram_rr_pick.sv
// Two-way round-robin picker; a lock restricts the grant to the lock owner.
module ram_rr_pick
  import grom_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  arb_state_e state,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (state)
      LOCK0:   gnt[REQ_CPU] = req[REQ_CPU];
      LOCK1:   gnt[REQ_AUX] = req[REQ_AUX];
      default: begin
        if (&req) gnt = (last_grant == REQ_AUX) ? 2'b01 : 2'b10;
        else      gnt = req;
      end
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between the CPU and the aux port:
// round-robin grant, bounded bus lock, and read-data return to the issuer.
module ram_arbiter
  import grom_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_LOCK   = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  ram_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_e            state;
  logic                  last_grant;
  logic                  rd_pend;
  logic                  rd_id;
  logic [CNT_W-1:0]      lock_cnt;
  logic [1:0]            lock_ovr;
  logic [1:0]            req, we_v, lock_v, pick, gnt, lock_hit;
  logic                  owner;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;
  logic [DATA_WIDTH-1:0] rd_bus;

  assign req    = {bus.req1, bus.req0};
  assign we_v   = {bus.we1, bus.we0};
  assign lock_v = {bus.lock1, bus.lock0};

  ram_rr_pick u_pick (
    .req        (req),
    .last_grant (last_grant),
    .state      (state),
    .gnt        (pick)
  );

  assign gnt      = reset_n ? pick : 2'b00;
  assign lock_hit = gnt & lock_v & ~lock_ovr;
  assign owner    = (state == LOCK1) ? REQ_AUX : REQ_CPU;

  assign bus.gnt0 = gnt[REQ_CPU];
  assign bus.gnt1 = gnt[REQ_AUX];

  // With no grant the RAM sees a discarded read of the CPU address.
  always_comb begin
    addr_sel   = bus.addr0;
    wdata_sel  = bus.wdata0;
    bus.ram_we = 1'b0;
    if (gnt[REQ_AUX]) begin
      addr_sel   = bus.addr1;
      wdata_sel  = bus.wdata1;
      bus.ram_we = bus.we1;
    end else if (gnt[REQ_CPU]) begin
      bus.ram_we = bus.we0;
    end
  end

  assign bus.ram_addr    = addr_sel;
  assign bus.ram_data_in = wdata_sel;

  // RAM data arrives one cycle after the grant, the same cycle rd_pend is high.
  assign rd_bus      = bus.ram_data_out;
  assign bus.rvalid0 = rd_pend & (rd_id == REQ_CPU);
  assign bus.rvalid1 = rd_pend & (rd_id == REQ_AUX);
  assign bus.rdata0  = bus.rvalid0 ? rd_bus : '0;
  assign bus.rdata1  = bus.rvalid1 ? rd_bus : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= REQ_AUX;
      lock_cnt   <= '0;
      lock_ovr   <= '0;
      rd_pend    <= 1'b0;
      rd_id      <= REQ_CPU;
    end else begin
      rd_pend <= |(gnt & ~we_v);
      rd_id   <= gnt[REQ_AUX];

      if (gnt[REQ_CPU])      last_grant <= REQ_CPU;
      else if (gnt[REQ_AUX]) last_grant <= REQ_AUX;

      // Override clears once the lock line is seen low; a later set wins.
      lock_ovr <= lock_ovr & lock_v;

      case (state)
        IDLE: begin
          if (MAX_LOCK == 1) begin
            lock_ovr <= (lock_ovr & lock_v) | lock_hit;
          end else if (lock_hit[REQ_CPU]) begin
            state    <= LOCK0;
            lock_cnt <= CNT_W'(1);
          end else if (lock_hit[REQ_AUX]) begin
            state    <= LOCK1;
            lock_cnt <= CNT_W'(1);
          end
        end
        LOCK0, LOCK1: begin
          if (!lock_v[owner]) begin
            state    <= IDLE;
            lock_cnt <= '0;
          end else if (lock_cnt == CNT_W'(MAX_LOCK - 1)) begin
            state           <= IDLE;
            lock_cnt        <= '0;
            last_grant      <= owner;
            lock_ovr[owner] <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          lock_cnt <= '0;
        end
      endcase
    end
  end

endmodule
